dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the core's load/store port.
- Accepts one load or store request at a time over a valid/ready handshake and performs the access on an internal word-organised RAM.
  - Stores apply byte/half/word lane strobes.
  - Loads return data right-justified, so the executor extends bits [7:0] or [15:0] directly.
- Sits between the executor's address/write_data/write_data_sig/read_data path and on-chip SRAM, replacing an ideal zero-latency memory.

Parameters:
- ADDR_W, 10, number of word-index bits; RAM depth is 2^ADDR_W 32-bit words.
- LATENCY, 1, extra wait cycles between request acceptance and response (0..15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  32  byte address.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer takes the response.
- resp_rdata  output  32  load data, addressed lane shifted to bit 0, upper bits zero; 0 for stores and errors.
- resp_err  output  1  access fault (range, or misalign when that feature is compiled in).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. RAM contents are not reset.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready:
    - latch addr/we/size/wdata;
    - compute offset = req_addr - BASE_ADDR and index = offset[ADDR_W+1:2];
    - range fault if offset >= 4*2^ADDR_W (unsigned, so addresses below BASE_ADDR wrap and also fault);
    - on no fault, perform the RAM read, or the strobed write, on this same edge;
    - go to WAIT if LATENCY>0, else RESP.
  - WAIT: req_ready=0; counter counts LATENCY-1 down to 0, then RESP.
  - RESP: resp_valid=1 and outputs stable until resp_ready. On resp_valid&resp_ready go to IDLE, with resp_valid=0 on the next cycle.
- No request is accepted in the handshake cycle; minimum throughput is one request per LATENCY+2 cycles.
- Store strobes, by addr[1:0]:
  - byte: lane addr[1:0] written with wdata[7:0].
  - half: lanes {addr[1],0} and {addr[1],1} written with wdata[15:0].
  - word: all four lanes written.
  - Other lanes are untouched.
- Load data: byte → {24'b0, word[8*addr[1:0]+:8]}; half → {16'b0, word[16*addr[1]+:16]}; word → whole word.
- Faulted access: no RAM write, resp_rdata=0, resp_err=1.
- req_size=11: treated as a fault, same as above.
- req_valid held while not in IDLE: ignored, not latched.
- rst asserted mid-transaction (WAIT or RESP): returns to IDLE next cycle and the response is dropped. A store already committed on the accept edge stays committed.
- Address wrap: offset arithmetic is 32-bit modulo.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - half with addr[0]=1 faults;
  - word with addr[1:0]!=0 faults;
  - a faulted store writes nothing; resp_err=1.
- Undefined:
  - misaligned accesses are not faulted;
  - low address bits are truncated to natural alignment (half uses addr[1], word ignores addr[1:0]);
  - the access proceeds normally.

Decomposition:
- Shared package holds:
  - the size encodings SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10;
  - the state encoding IDLE/WAIT/RESP;
  - a lane-mask helper function (size, addr[1:0]) → 4-bit strobe, reused by the load/store unit.
- One natural sub-module: dmem_byte_ram. It is a 2^ADDR_W × 32 single-port RAM with a 4-bit write strobe and a registered read, so that it can map to block RAM.

Test Plan:
- Word round trip:
  - stimulus: LATENCY=1; store word 32'hDEADBEEF at 0x10, then load word at 0x10;
  - required: each response has resp_valid exactly 3 cycles after acceptance (accept edge, 1 wait cycle, then RESP), with resp_ready held high; resp_rdata=32'hDEADBEEF, resp_err=0.
- Byte and half lanes:
  - stimulus: store word 32'h11223344 at 0x20, store byte 8'hAA at 0x22, store half 16'h5566 at 0x20;
  - required: load word returns 32'h11AA5566; load byte 0x23 returns 32'h00000011; load half 0x22 returns 32'h000011AA.
- Backpressure:
  - stimulus: resp_ready=0 for 5 cycles in RESP, with req_valid held high;
  - required: resp_valid/rdata stable, req_ready=0, no second accept; on release, IDLE next cycle, then the new request is accepted.
- Range fault:
  - stimulus: ADDR_W=10, store word at BASE_ADDR+0x1000, then load word at BASE_ADDR+0x0;
  - required: resp_err=1, rdata=0; the original content at word 0 is unchanged.
- Misalignment:
  - stimulus: with DMEM_MISALIGN_CHECK_EN, load word at 0x12;
  - required: resp_err=1. Without the macro, the same load returns the word at 0x10 with err=0.
- Reset mid-op:
  - stimulus: LATENCY=4; assert rst during WAIT;
  - required: next cycle state=IDLE, req_ready=1, resp_valid=0, and no response is ever produced for that request.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// FSM state encoding and the byte-lane strobe helper.
package dmem_responder_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte-lane strobe for an access of the given size at the given low address
  // bits. Halves and words are truncated to natural alignment; the reserved
  // size yields an empty mask.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] lane);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SIZE_B:  mask = 4'b0001 << lane;
      SIZE_H:  mask = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the executor (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_byte_ram.sv
// Single-port 2^ADDR_W x 32 RAM with per-byte write strobes and a registered
// read port, written so that it maps onto block RAM. Contents are not reset.
module dmem_byte_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata_q;

  // Strobed byte-lane write and registered read; rdata holds while en is low.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the core's load/store port. Accepts one
// request at a time, performs it on the internal RAM on the accept edge, waits
// LATENCY cycles and then holds the response until it is taken.
// Optional build macro DMEM_MISALIGN_CHECK_EN faults misaligned half/word
// accesses; without it low address bits are truncated to natural alignment.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  dmem_responder_if.slave bus
);

  localparam logic [32:0] RANGE_BYTES = 33'(64'd4 << ADDR_W);
  localparam logic [3:0]  LAT_M1      = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic        err_q, err_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;

  logic [31:0] offset;
  logic        range_fault;
  logic        size_fault;
  logic        misalign;
  logic        fault;
  logic        accept;

  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       load_data;

  // Decode the incoming request: window offset, fault checks and RAM controls.
  always_comb begin
    offset      = bus.req_addr - BASE_ADDR;
    range_fault = ({1'b0, offset} >= RANGE_BYTES);
    size_fault  = (bus.req_size == 2'b11);
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign    = ((bus.req_size == SIZE_H) && offset[0]) ||
                  ((bus.req_size == SIZE_W) && (offset[1:0] != 2'b00));
`else
    misalign    = 1'b0;
`endif
    fault       = range_fault | size_fault | misalign;
    accept      = req_ready_q & bus.req_valid;

    ram_en    = accept & ~fault & ~rst;
    ram_we    = bus.req_we ? lane_mask(bus.req_size, offset[1:0]) : 4'b0000;
    ram_addr  = offset[ADDR_W+1:2];
    case (bus.req_size)
      SIZE_B:  ram_wdata = {4{bus.req_wdata[7:0]}};
      SIZE_H:  ram_wdata = {2{bus.req_wdata[15:0]}};
      default: ram_wdata = bus.req_wdata;
    endcase
  end

  dmem_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Next-state logic: latch the request on accept, count down, hold response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    lane_d  = lane_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d   = bus.req_we;
          size_d = bus.req_size;
          lane_d = offset[1:0];
          err_d  = fault;
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  // State and registered handshake outputs, synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      size_q       <= SIZE_B;
      lane_q       <= 2'b00;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Right-justify the addressed lane of the held RAM word; the RAM read port
  // only updates on accept, so this is stable for the whole response.
  always_comb begin
    case (size_q)
      SIZE_B:  load_data = {24'b0, ram_rdata[{lane_q, 3'b000} +: 8]};
      SIZE_H:  load_data = {16'b0, ram_rdata[{lane_q[1], 4'b0000} +: 16]};
      default: load_data = ram_rdata;
    endcase
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_valid_q & err_q;
  assign bus.resp_rdata = (resp_valid_q && !err_q && !we_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance A (LATENCY=1, base 0) covers
// round trips, lanes, backpressure, range and alignment; instance B
// (LATENCY=4, base 0x8000) covers long latency, mid-transaction reset and
// addresses below the base.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   vectors;
  int   miscompares;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.ADDR_W(10), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(4), .BASE_ADDR(32'h0000_8000)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One comparison: counts it, and counts and reports a miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // One full transaction on instance A (port_b=0) or B (port_b=1), entered and
  // left at a negedge with the instance idle. cycles counts the accept cycle as
  // 1 and reports the cycle in which resp_valid is first seen.
  task automatic applyStimulus(input bit port_b, input logic we, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err,
                               output int cycles);
    logic seen;
    if (!port_b) begin
      bus_a.req_valid = 1'b1; bus_a.req_we = we; bus_a.req_size = size;
      bus_a.req_addr = addr; bus_a.req_wdata = wdata; bus_a.resp_ready = 1'b1;
    end else begin
      bus_b.req_valid = 1'b1; bus_b.req_we = we; bus_b.req_size = size;
      bus_b.req_addr = addr; bus_b.req_wdata = wdata; bus_b.resp_ready = 1'b1;
    end
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    bus_b.req_valid = 1'b0;
    cycles = 2;
    seen = port_b ? bus_b.resp_valid : bus_a.resp_valid;
    while (seen !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
      seen = port_b ? bus_b.resp_valid : bus_a.resp_valid;
    end
    checkOutput("resp_valid_seen", {31'b0, seen}, 32'd1);
    rdata = port_b ? bus_b.resp_rdata : bus_a.resp_rdata;
    err   = port_b ? bus_b.resp_err : bus_a.resp_err;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        er;
  int          cyc;
  logic        seen_resp;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_size = SIZE_W;
    bus_a.req_addr = 32'h0; bus_a.req_wdata = 32'h0; bus_a.resp_ready = 1'b1;
    bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_size = SIZE_W;
    bus_b.req_addr = 32'h0; bus_b.req_wdata = 32'h0; bus_b.resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_req_ready", {31'b0, bus_a.req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'b0, bus_a.resp_valid}, 32'd0);
    checkOutput("rst_resp_rdata", bus_a.resp_rdata, 32'h0);
    checkOutput("rst_resp_err", {31'b0, bus_a.resp_err}, 32'd0);

    $display("[TB] word round trip");
    applyStimulus(0, 1'b1, SIZE_W, 32'h10, 32'hDEADBEEF, rd, er, cyc);
    checkOutput("st_w_latency", cyc, 32'd3);
    checkOutput("st_w_err", {31'b0, er}, 32'd0);
    checkOutput("st_w_rdata", rd, 32'h0);
    applyStimulus(0, 1'b0, SIZE_W, 32'h10, 32'h0, rd, er, cyc);
    checkOutput("ld_w_latency", cyc, 32'd3);
    checkOutput("ld_w_rdata", rd, 32'hDEADBEEF);
    checkOutput("ld_w_err", {31'b0, er}, 32'd0);

    $display("[TB] byte and half lanes");
    applyStimulus(0, 1'b1, SIZE_W, 32'h20, 32'h11223344, rd, er, cyc);
    applyStimulus(0, 1'b1, SIZE_B, 32'h22, 32'h000000AA, rd, er, cyc);
    applyStimulus(0, 1'b1, SIZE_H, 32'h20, 32'h00005566, rd, er, cyc);
    applyStimulus(0, 1'b0, SIZE_W, 32'h20, 32'h0, rd, er, cyc);
    checkOutput("lanes_word", rd, 32'h11AA5566);
    applyStimulus(0, 1'b0, SIZE_B, 32'h23, 32'h0, rd, er, cyc);
    checkOutput("lanes_byte23", rd, 32'h00000011);
    applyStimulus(0, 1'b0, SIZE_H, 32'h22, 32'h0, rd, er, cyc);
    checkOutput("lanes_half22", rd, 32'h000011AA);

    $display("[TB] backpressure");
    bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_size = SIZE_W;
    bus_a.req_addr = 32'h20; bus_a.resp_ready = 1'b0;
    @(negedge clk);
    bus_a.req_size = SIZE_B;
    bus_a.req_addr = 32'h10;
    cyc = 0;
    while (bus_a.resp_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_resp_valid", {31'b0, bus_a.resp_valid}, 32'd1);
      checkOutput("bp_resp_rdata", bus_a.resp_rdata, 32'h11AA5566);
      checkOutput("bp_req_ready", {31'b0, bus_a.req_ready}, 32'd0);
      @(negedge clk);
    end
    bus_a.resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_ready", {31'b0, bus_a.req_ready}, 32'd1);
    checkOutput("bp_release_valid", {31'b0, bus_a.resp_valid}, 32'd0);
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    cyc = 2;
    while (bus_a.resp_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("bp_next_latency", cyc, 32'd3);
    checkOutput("bp_next_rdata", bus_a.resp_rdata, 32'h000000EF);
    @(negedge clk);

    $display("[TB] range fault");
    applyStimulus(0, 1'b1, SIZE_W, 32'h0, 32'hCAFEF00D, rd, er, cyc);
    applyStimulus(0, 1'b1, SIZE_W, 32'h1000, 32'h12345678, rd, er, cyc);
    checkOutput("range_st_err", {31'b0, er}, 32'd1);
    checkOutput("range_st_rdata", rd, 32'h0);
    applyStimulus(0, 1'b0, SIZE_W, 32'h0, 32'h0, rd, er, cyc);
    checkOutput("range_word0_kept", rd, 32'hCAFEF00D);
    checkOutput("range_word0_err", {31'b0, er}, 32'd0);
    applyStimulus(0, 1'b1, SIZE_W, 32'hFFC, 32'hA5A55A5A, rd, er, cyc);
    applyStimulus(0, 1'b0, SIZE_W, 32'hFFC, 32'h0, rd, er, cyc);
    checkOutput("range_last_word", rd, 32'hA5A55A5A);
    checkOutput("range_last_err", {31'b0, er}, 32'd0);
    applyStimulus(0, 1'b0, SIZE_W, 32'h1000, 32'h0, rd, er, cyc);
    checkOutput("range_ld_err", {31'b0, er}, 32'd1);
    applyStimulus(0, 1'b0, 2'b11, 32'h10, 32'h0, rd, er, cyc);
    checkOutput("size11_err", {31'b0, er}, 32'd1);
    checkOutput("size11_rdata", rd, 32'h0);

    $display("[TB] misalignment");
    applyStimulus(0, 1'b0, SIZE_W, 32'h12, 32'h0, rd, er, cyc);
`ifdef DMEM_MISALIGN_CHECK_EN
    checkOutput("mis_w_err", {31'b0, er}, 32'd1);
    checkOutput("mis_w_rdata", rd, 32'h0);
`else
    checkOutput("mis_w_err", {31'b0, er}, 32'd0);
    checkOutput("mis_w_rdata", rd, 32'hDEADBEEF);
`endif
    applyStimulus(0, 1'b0, SIZE_H, 32'h21, 32'h0, rd, er, cyc);
`ifdef DMEM_MISALIGN_CHECK_EN
    checkOutput("mis_h_err", {31'b0, er}, 32'd1);
`else
    checkOutput("mis_h_rdata", rd, 32'h00005566);
`endif

    $display("[TB] latency 4 and reset mid-op");
    applyStimulus(1, 1'b1, SIZE_W, 32'h8000, 32'h0BADCAFE, rd, er, cyc);
    checkOutput("b_latency", cyc, 32'd6);
    checkOutput("b_st_err", {31'b0, er}, 32'd0);
    bus_b.req_valid = 1'b1; bus_b.req_we = 1'b1; bus_b.req_size = SIZE_W;
    bus_b.req_addr = 32'h8004; bus_b.req_wdata = 32'h600DF00D;
    @(negedge clk);
    bus_b.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("b_wait_ready", {31'b0, bus_b.req_ready}, 32'd0);
    rst_b = 1'b1;
    @(negedge clk);
    checkOutput("b_rst_ready", {31'b0, bus_b.req_ready}, 32'd1);
    checkOutput("b_rst_valid", {31'b0, bus_b.resp_valid}, 32'd0);
    rst_b = 1'b0;
    seen_resp = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_b.resp_valid === 1'b1) seen_resp = 1'b1;
    end
    checkOutput("b_no_resp", {31'b0, seen_resp}, 32'd0);
    applyStimulus(1, 1'b0, SIZE_W, 32'h8004, 32'h0, rd, er, cyc);
    checkOutput("b_committed", rd, 32'h600DF00D);
    applyStimulus(1, 1'b0, SIZE_W, 32'h8000, 32'h0, rd, er, cyc);
    checkOutput("b_word0", rd, 32'h0BADCAFE);
    applyStimulus(1, 1'b0, SIZE_W, 32'h7FFC, 32'h0, rd, er, cyc);
    checkOutput("b_below_base_err", {31'b0, er}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
